// File: rtl/hazard_stall_unit.sv
// Pipeline hazard detector: load-use and data-memory wait stalls, a scoreboard of
// in-flight load destinations, and a saturating stall-cycle counter.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// RUN         | no hazard seen last cycle, pipeline flowing
// MEM_WAIT    | MEM stage waiting on a data-memory response, whole pipe held
// LOAD_BUBBLE | one NOP injected into EX behind a load, front end held
module hazard_stall_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       rd_EX,
  input  logic             mem_valid,
  input  logic             mem_is_mem_op,
  input  logic             mem_is_load,
  input  logic [4:0]       rd_MEM,
  input  logic             dmem_resp,
  output logic             stall_IF,
  output logic             stall_ID,
  output logic             stall_EX,
  output logic             stall_MEM,
  output logic             bubble_EX,
  output logic             bubble_WB,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MEM_WAIT    = 2'd1,
    LOAD_BUBBLE = 2'd2
  } state_t;

  state_t state;

  logic mem_wait;
  logic load_use;
  logic rs1_hit;
  logic rs2_hit;
  logic load_leaves_ex;
  logic load_returns;
  logic [31:0] set_vec;
  logic [31:0] clr_vec;

  always_comb begin
    rs1_hit  = use_rs1 && (rs1_ID == rd_EX);
    rs2_hit  = use_rs2 && (rs2_ID == rd_EX);
    mem_wait = mem_valid && mem_is_mem_op && !dmem_resp;
    load_use = id_valid && ex_valid && ex_is_load && (rd_EX != 5'd0) && (rs1_hit || rs2_hit);
  end

  // Outputs follow the inputs with zero latency; reset forces them low at once.
  always_comb begin
    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    stall_EX  = 1'b0;
    stall_MEM = 1'b0;
    bubble_EX = 1'b0;
    bubble_WB = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        stall_IF  = 1'b1;
        stall_ID  = 1'b1;
        stall_EX  = 1'b1;
        stall_MEM = 1'b1;
        bubble_WB = 1'b1;
      end else if (load_use) begin
        stall_IF  = 1'b1;
        stall_ID  = 1'b1;
        bubble_EX = 1'b1;
      end
    end
  end

  always_comb begin
    load_leaves_ex = ex_valid && ex_is_load && !stall_EX && (rd_EX != 5'd0);
    load_returns   = mem_valid && mem_is_load && dmem_resp;
    set_vec = 32'd0;
    clr_vec = 32'd0;
    if (load_leaves_ex) set_vec[rd_EX] = 1'b1;
    if (load_returns)   clr_vec[rd_MEM] = 1'b1;
  end

  // Set is applied after clear so a same-index collision leaves the bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 32'd0;
    end else begin
      pending <= ((pending & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall_IF && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN: begin
          if (mem_wait)      state <= MEM_WAIT;
          else if (load_use) state <= LOAD_BUBBLE;
          else               state <= RUN;
        end
        MEM_WAIT: begin
          if (mem_wait)      state <= MEM_WAIT;
          else if (load_use) state <= LOAD_BUBBLE;
          else               state <= RUN;
        end
        LOAD_BUBBLE: begin
          if (mem_wait) state <= MEM_WAIT;
          else          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed hazard scenarios then random traffic,
// checked against a queue-fed reference model by an independent monitor.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid, use_rs1, use_rs2, ex_valid, ex_is_load;
  logic mem_valid, mem_is_mem_op, mem_is_load, dmem_resp;
  logic [4:0] rs1_ID, rs2_ID, rd_EX, rd_MEM;

  logic stall_IF, stall_ID, stall_EX, stall_MEM, bubble_EX, bubble_WB;
  logic [31:0] pending;
  logic [15:0] stall_count;

  logic s4_IF, s4_ID, s4_EX, s4_MEM, b4_EX, b4_WB;
  logic [31:0] pending4;
  logic [3:0] stall_count4;

  always #5 clk = ~clk;

  hazard_stall_unit dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .rd_EX(rd_EX), .mem_valid(mem_valid), .mem_is_mem_op(mem_is_mem_op),
    .mem_is_load(mem_is_load), .rd_MEM(rd_MEM), .dmem_resp(dmem_resp),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_EX(stall_EX), .stall_MEM(stall_MEM),
    .bubble_EX(bubble_EX), .bubble_WB(bubble_WB), .pending(pending),
    .stall_count(stall_count)
  );

  hazard_stall_unit #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
    .rd_EX(rd_EX), .mem_valid(mem_valid), .mem_is_mem_op(mem_is_mem_op),
    .mem_is_load(mem_is_load), .rd_MEM(rd_MEM), .dmem_resp(dmem_resp),
    .stall_IF(s4_IF), .stall_ID(s4_ID), .stall_EX(s4_EX), .stall_MEM(s4_MEM),
    .bubble_EX(b4_EX), .bubble_WB(b4_WB), .pending(pending4),
    .stall_count(stall_count4)
  );

  // Reference state names: 0 running, 1 waiting on memory, 2 load bubble
  localparam int S_RUN = 0, S_MW = 1, S_LB = 2;

  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] pend;
    int          c16;
    int          c4;
    int          st;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  bit driver_done = 0;

  logic [31:0] m_pend;
  int m_c16, m_c4, m_st;

  task automatic idle();
    id_valid = 0; use_rs1 = 0; use_rs2 = 0; rs1_ID = 0; rs2_ID = 0;
    ex_valid = 0; ex_is_load = 0; rd_EX = 0;
    mem_valid = 0; mem_is_mem_op = 0; mem_is_load = 0; rd_MEM = 0; dmem_resp = 0;
  endtask

  // Expectation for the current inputs, then advance the model across the next edge.
  task automatic cyc();
    exp_t e;
    bit mw, lu, hit;
    int nst;
    mw  = mem_valid && mem_is_mem_op && !dmem_resp;
    hit = (use_rs1 && rs1_ID == rd_EX) || (use_rs2 && rs2_ID == rd_EX);
    lu  = id_valid && ex_valid && ex_is_load && rd_EX != 0 && hit;
    if (rst) begin
      m_pend = 0; m_c16 = 0; m_c4 = 0; m_st = S_RUN;
    end
    e.ctl  = rst ? 6'b000000 : mw ? 6'b111101 : lu ? 6'b110010 : 6'b000000;
    e.pend = m_pend; e.c16 = m_c16; e.c4 = m_c4; e.st = m_st;
    exp_q.push_back(e);
    if (!rst) begin
      if (mem_valid && mem_is_load && dmem_resp) m_pend[rd_MEM] = 1'b0;
      if (ex_valid && ex_is_load && !mw && rd_EX != 0) m_pend[rd_EX] = 1'b1;
      m_pend[0] = 1'b0;
      if (mw || lu) begin
        if (m_c16 < 65535) m_c16++;
        if (m_c4 < 15) m_c4++;
      end
      if (mw) nst = S_MW;
      else if (lu && m_st != S_LB) nst = S_LB;
      else nst = S_RUN;
      m_st = nst;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctl", {stall_IF, stall_ID, stall_EX, stall_MEM, bubble_EX, bubble_WB}, e.ctl);
        chk("ctl4", {s4_IF, s4_ID, s4_EX, s4_MEM, b4_EX, b4_WB}, e.ctl);
        chk("pending", pending, e.pend);
        chk("pending4", pending4, e.pend);
        chk("stall_count", stall_count, e.c16);
        chk("stall_count4", stall_count4, e.c4);
        chk("state", int'(dut.state), e.st);
      end
    end
  end

  initial begin : driver
    idle();
    m_pend = 0; m_c16 = 0; m_c4 = 0; m_st = S_RUN;
    @(posedge clk);
    #1;
    cyc(); cyc();
    rst = 0;
    cyc();
    // load-use on rs1: one stall cycle, then quiet
    ex_valid = 1; ex_is_load = 1; rd_EX = 5; id_valid = 1; rs1_ID = 5; use_rs1 = 1;
    cyc();
    idle(); cyc();
    // x0 destination and unused matching rs2 never stall
    ex_valid = 1; ex_is_load = 1; rd_EX = 0; id_valid = 1; rs1_ID = 0; use_rs1 = 1;
    cyc();
    rd_EX = 9; rs1_ID = 3; rs2_ID = 9; use_rs2 = 0;
    cyc();
    idle(); cyc();
    // load x7 leaves EX, then waits 3 cycles in MEM before returning
    ex_valid = 1; ex_is_load = 1; rd_EX = 7; cyc();
    idle(); mem_valid = 1; mem_is_mem_op = 1; mem_is_load = 1; rd_MEM = 7;
    repeat (3) cyc();
    dmem_resp = 1; cyc();
    idle(); cyc();
    // memory wait and load-use together; bubble follows the response
    mem_valid = 1; mem_is_mem_op = 1; mem_is_load = 1; rd_MEM = 3;
    ex_valid = 1; ex_is_load = 1; rd_EX = 4; id_valid = 1; rs2_ID = 4; use_rs2 = 1;
    repeat (2) cyc();
    dmem_resp = 1; cyc();
    mem_valid = 0; dmem_resp = 0; cyc();
    idle(); cyc();
    // long memory wait saturates the narrow counter
    mem_valid = 1; mem_is_mem_op = 1;
    repeat (20) cyc();
    idle(); cyc();
    // reset lands in the middle of a memory wait with x5 pending
    ex_valid = 1; ex_is_load = 1; rd_EX = 5; cyc();
    idle(); mem_valid = 1; mem_is_mem_op = 1; rd_MEM = 2;
    repeat (2) cyc();
    rst = 1; cyc();
    rst = 0; idle(); cyc();
    // random traffic over a small register window to force collisions
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      id_valid = $urandom_range(0, 1); use_rs1 = $urandom_range(0, 1);
      use_rs2 = $urandom_range(0, 1);
      rs1_ID = 5'($urandom_range(0, 3)); rs2_ID = 5'($urandom_range(0, 3));
      ex_valid = $urandom_range(0, 1); ex_is_load = $urandom_range(0, 1);
      rd_EX = 5'($urandom_range(0, 3));
      mem_valid = $urandom_range(0, 1); mem_is_mem_op = $urandom_range(0, 1);
      mem_is_load = mem_is_mem_op & 1'($urandom_range(0, 1));
      rd_MEM = 5'($urandom_range(0, 3)); dmem_resp = ($urandom_range(0, 2) != 0);
      cyc();
    end
    rst = 0; idle(); cyc();
    driver_done = 1;
  end

  initial begin : finisher
    int guard = 0;
    while (!driver_done && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    total++;
    if (!driver_done || exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: driver_done=%0d queued=%0d expected done=1 queued=0",
               driver_done, exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
